// File: rtl/view_step_input_pkg.sv
// Shared constants for the board input front end: view codes and selector width.
package view_step_input_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  typedef enum logic [SEL_W-1:0] {
    VIEW_PC_LO    = 3'd0,
    VIEW_PC_HI    = 3'd1,
    VIEW_REG_LO   = 3'd2,
    VIEW_REG_HI   = 3'd3,
    VIEW_INSTR_LO = 3'd4,
    VIEW_INSTR_HI = 3'd5
  } view_e;

endpackage

// File: rtl/btn_debounce.sv
// Polarity-normalising 2-flop synchroniser, stability-count debouncer and rising-edge strobe.
module btn_debounce
  import view_step_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            raw_norm;
  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Normalise before the synchroniser so reset can load the released level as 0.
  assign raw_norm = ACTIVE_LOW ? ~btn_i : btn_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_norm;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/view_step_input.sv
// Button/switch front end: display view selector and CPU clock-enable (step or free run).
module view_step_input
  import view_step_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned NUM_VIEWS       = 6,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             btn_step,
  input  logic             sw_run,
  output logic [SEL_W-1:0] sel,
  output logic             cpu_en,
  output logic             step_pulse,
  output logic             run_mode
);

  localparam logic [SEL_W-1:0] SelMax = SEL_W'(NUM_VIEWS - 1);

  logic next_press, prev_press, step_press;
  logic next_level_unused, prev_level_unused, step_level_unused;
  logic run_level, run_press_unused;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             cpu_en_q, cpu_en_d;
  logic             step_pulse_q, step_pulse_d;
  logic             run_mode_q, run_mode_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_next (
    .clk_i(clk), .reset_i(reset), .btn_i(btn_next),
    .level_o(next_level_unused), .press_o(next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_prev (
    .clk_i(clk), .reset_i(reset), .btn_i(btn_prev),
    .level_o(prev_level_unused), .press_o(prev_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_step (
    .clk_i(clk), .reset_i(reset), .btn_i(btn_step),
    .level_o(step_level_unused), .press_o(step_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0)) u_run (
    .clk_i(clk), .reset_i(reset), .btn_i(sw_run),
    .level_o(run_level), .press_o(run_press_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q        <= VIEW_PC_LO;
      cpu_en_q     <= 1'b0;
      step_pulse_q <= 1'b0;
      run_mode_q   <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      cpu_en_q     <= cpu_en_d;
      step_pulse_q <= step_pulse_d;
      run_mode_q   <= run_mode_d;
    end
  end

  always_comb begin
    sel_d = sel_q;
    case ({next_press, prev_press})
      2'b10:   sel_d = (sel_q == SelMax) ? '0 : sel_q + SEL_W'(1);
      2'b01:   sel_d = (sel_q == '0) ? SelMax : sel_q - SEL_W'(1);
      default: sel_d = sel_q;
    endcase
  end

  // Gate on the incoming run level so cpu_en drops in the same cycle run_mode falls.
  always_comb begin
    run_mode_d   = run_level;
    step_pulse_d = step_press & ~run_level;
    cpu_en_d     = run_level | step_pulse_d;
  end

  assign sel        = sel_q;
  assign cpu_en     = cpu_en_q;
  assign step_pulse = step_pulse_q;
  assign run_mode   = run_mode_q;

endmodule

// File: tb/tb_view_step_input.sv
// Scoreboard bench: a behavioural model queues expected output changes, a monitor checks them.
module tb_view_step_input;

  localparam int D  = 4;
  localparam int NV = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next, btn_prev, btn_step, sw_run;
  logic [2:0] sel;
  logic       cpu_en, step_pulse, run_mode;

  view_step_input #(.DEBOUNCE_CYCLES(D), .NUM_VIEWS(NV), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
    .btn_step(btn_step), .sw_run(sw_run), .sel(sel), .cpu_en(cpu_en),
    .step_pulse(step_pulse), .run_mode(run_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } ev_t;

  ev_t evq[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  // Reference model: synced value is the pressed-level input two cycles earlier; the
  // debounced level adopts it once the last D synced samples all disagree with it.
  bit         lvl [4];
  bit         lvl_prev [4];
  bit         dly [4][2];
  bit         win [4][D];
  int         wfill [4];
  logic [2:0] exp_sel = 0;
  bit         exp_cpu = 0, exp_step = 0, exp_run = 0;
  logic [5:0] exp_last = '0;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      lvl[i] = 0; lvl_prev[i] = 0; dly[i][0] = 0; dly[i][1] = 0; wfill[i] = 0;
    end
    exp_sel = 0; exp_cpu = 0; exp_step = 0; exp_run = 0;
  endtask

  task automatic model_edge(input bit rst, input bit nin [4]);
    bit press [4];
    bit s, all_diff;
    if (rst) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 4; i++) press[i] = lvl[i] & ~lvl_prev[i];
    if (press[0] && !press[1]) exp_sel = (int'(exp_sel) == NV - 1) ? 3'd0 : exp_sel + 3'd1;
    else if (press[1] && !press[0]) exp_sel = (exp_sel == 0) ? 3'(NV - 1) : exp_sel - 3'd1;
    exp_run  = lvl[3];
    exp_step = press[2] & ~lvl[3];
    exp_cpu  = lvl[3] | exp_step;
    for (int i = 0; i < 4; i++) begin
      lvl_prev[i] = lvl[i];
      s = dly[i][0];
      if (wfill[i] < D) begin
        win[i][wfill[i]] = s;
        wfill[i]++;
      end else begin
        for (int k = 0; k < D - 1; k++) win[i][k] = win[i][k+1];
        win[i][D-1] = s;
      end
      all_diff = (wfill[i] == D);
      for (int k = 0; k < wfill[i]; k++) if (win[i][k] == lvl[i]) all_diff = 0;
      if (all_diff) lvl[i] = s;
      dly[i][0] = dly[i][1];
      dly[i][1] = nin[i];
    end
  endtask

  task automatic tick();
    bit         nin [4];
    logic [5:0] v;
    @(posedge clk);
    nin[0] = ~btn_next; nin[1] = ~btn_prev; nin[2] = ~btn_step; nin[3] = sw_run;
    model_edge(reset, nin);
    cyc++;
    v = {exp_sel, exp_cpu, exp_step, exp_run};
    if (v != exp_last) evq.push_back('{cyc: cyc, vec: v});
    exp_last = v;
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  // Monitor: every change of the DUT output vector must match the next queued event.
  logic [5:0] dut_last = '0;
  always @(negedge clk) begin
    logic [5:0] v;
    ev_t        e;
    if (cyc >= 1) begin
      v = {sel, cpu_en, step_pulse, run_mode};
      if (v !== dut_last) begin
        total++;
        if (evq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change at cycle %0d: got %h expected no change", cyc, v);
        end else begin
          e = evq.pop_front();
          if (e.cyc != cyc || e.vec !== v) begin
            bad++;
            $display("FAIL output_event: got %h at cycle %0d expected %h at cycle %0d",
                     v, cyc, e.vec, e.cyc);
          end
        end
        dut_last = v;
      end
    end
  end

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       btn_next = v;
      1:       btn_prev = v;
      default: btn_step = v;
    endcase
  endtask

  task automatic press_btn(input int which, input int hold, input int idle);
    set_btn(which, 1'b0);
    repeat (hold) tick();
    set_btn(which, 1'b1);
    repeat (idle) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  int seq_exp [6] = '{1, 2, 3, 4, 5, 0};
  int n_step, n_cpu, n_cpu_low, guard;

  initial begin
    reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b1; btn_step = 1'b1; sw_run = 1'b0;
    repeat (3) tick();
    check("reset_sel", sel, 0);
    check("reset_cpu_en", cpu_en, 0);
    check("reset_step_pulse", step_pulse, 0);
    check("reset_run_mode", run_mode, 0);
    reset = 1'b0;
    repeat (12) tick();
    btn_next = 1'b1;
    repeat (10) tick();
    check("held_through_reset_sel", sel, 1);

    // Glitch rejection then exact latency.
    do_reset();
    btn_next = 1'b0;
    repeat (3) tick();
    btn_next = 1'b1;
    repeat (10) tick();
    check("glitch_sel", sel, 0);
    btn_next = 1'b0;
    repeat (6) tick();
    check("latency_before_sel", sel, 0);
    tick();
    check("latency_at_sel", sel, 1);
    repeat (3) tick();
    btn_next = 1'b1;
    repeat (10) tick();
    check("no_repeat_sel", sel, 1);

    // Full wrap forward, then back one.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press_btn(0, 8, 8);
      check($sformatf("next_seq_%0d", i), sel, seq_exp[i]);
    end
    press_btn(1, 8, 8);
    check("prev_wrap_sel", sel, 5);

    btn_next = 1'b0; btn_prev = 1'b0;
    repeat (10) tick();
    btn_next = 1'b1; btn_prev = 1'b1;
    repeat (10) tick();
    check("both_pressed_sel", sel, 5);

    // Single stepping.
    for (int r = 0; r < 2; r++) begin
      n_step = 0; n_cpu = 0;
      btn_step = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        n_step += int'(step_pulse);
        n_cpu  += int'(cpu_en);
      end
      btn_step = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        n_step += int'(step_pulse);
        n_cpu  += int'(cpu_en);
      end
      check($sformatf("step%0d_pulse_count", r), n_step, 1);
      check($sformatf("step%0d_cpu_en_count", r), n_cpu, 1);
    end

    // Free run, step ignored, then fall back.
    sw_run = 1'b1;
    guard = 0;
    do begin tick(); guard++; end while (run_mode !== 1'b1 && guard < 20);
    check("run_mode_rise", run_mode, 1);
    n_step = 0; n_cpu_low = 0;
    btn_step = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) btn_step = 1'b1;
      tick();
      n_step    += int'(step_pulse);
      n_cpu_low += int'(!cpu_en);
    end
    check("run_step_pulse_count", n_step, 0);
    check("run_cpu_en_low_count", n_cpu_low, 0);
    repeat (6) tick();
    sw_run = 1'b0;
    guard = 0;
    do begin tick(); guard++; end while (run_mode !== 1'b0 && guard < 20);
    check("run_mode_fall", run_mode, 0);
    check("cpu_en_at_run_fall", cpu_en, 0);

    // Randomised traffic, checked only by the scoreboard.
    for (int seg = 0; seg < 400; seg++) begin
      btn_next = ($urandom_range(0, 2) != 0);
      btn_prev = ($urandom_range(0, 2) != 0);
      btn_step = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0) sw_run = ~sw_run;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 10)) tick();
    end
    btn_next = 1'b1; btn_prev = 1'b1; btn_step = 1'b1; sw_run = 1'b0;
    repeat (12) tick();
    check("events_drained", evq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/view_step_input.md
Name: view_step_input

Overview:
- User-to-processor input front end for the monocycle board build.
- Takes raw push-buttons and a run switch, then synchronizes and debounces them.
- Produces the 3-bit display view selector `sel`, consumed by the 7-segment display path.
- Also produces the CPU clock-enable: single-step pulses or continuous run.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz).
- NUM_VIEWS, 6: number of legal `sel` values (0..NUM_VIEWS-1); must be ≤ 8.
- BTN_ACTIVE_LOW, 1: 1 means raw buttons read 0 when pressed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_next  in  1  raw button, advance view
- btn_prev  in  1  raw button, go back one view
- btn_step  in  1  raw button, execute one instruction
- sw_run  in  1  raw switch, 1 = free-run CPU
- sel  out  3  display view selector (0 PC lo, 1 PC hi, 2 reg lo, 3 reg hi, 4 instr lo, 5 instr hi)
- cpu_en  out  1  clock-enable to PC/register-file write logic
- step_pulse  out  1  one-cycle strobe per accepted step press (debug LED / trace)
- run_mode  out  1  debounced sw_run level

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values:
  - sel=0, cpu_en=0, step_pulse=0, run_mode=0.
  - All synchronizer flops at the released level, all debounced levels 0, all counters 0.
- Input conditioning (per input):
  - Polarity is normalized before synchronization: pressed = 1 internally. sw_run is never inverted.
  - 2-flop synchronizer.
- Debounce (per input):
  - Counter increments while the synced level ≠ the debounced level.
  - Counter clears to 0 whenever the levels are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles never changes the debounced level.
- Edge detect: a registered previous debounced level gives a one-cycle `press` on each 0→1 transition only. Releases produce nothing.
- Latency: raw button held from the edge at cycle t gives `press` high during cycle t+DEBOUNCE_CYCLES+2 (2 sync + DEBOUNCE_CYCLES count). `sel` and `step_pulse` update at the next edge (t+DEBOUNCE_CYCLES+3).
- `sel` update, registered:
  - next only: sel = (sel==NUM_VIEWS-1) ? 0 : sel+1.
  - prev only: sel = (sel==0) ? NUM_VIEWS-1 : sel-1.
  - next and prev in the same cycle: sel unchanged.
  - Values ≥ NUM_VIEWS are unreachable.
- run_mode equals the debounced sw_run level, registered.
- cpu_en, registered:
  - run_mode=1: cpu_en=1 every cycle; step presses are ignored and do not raise step_pulse.
  - run_mode=0: cpu_en = step_pulse, exactly one cycle high per step press. Holding the button gives no repeat.
- Mode change: run_mode 1→0 drops cpu_en to 0 in the same cycle run_mode falls. A step press coincident with that fall is honoured (run_mode=0 in that cycle).
- Reset mid-press: state clears. A button still held after reset release debounces afresh and yields exactly one press.

Decomposition:
- Shared package holds:
  - view codes VIEW_PC_LO..VIEW_INSTR_HI (3'd0..3'd5);
  - SEL_W = 3;
  - default DEBOUNCE_CYCLES.
- One sub-module, `btn_debounce` (sync + counter + rising-edge pulse; parameters DEBOUNCE_CYCLES, ACTIVE_LOW; outputs level and press). Instantiated four times; the sw_run instance uses ACTIVE_LOW=0 and only the level output.
- Top level holds the sel up/down counter and the cpu_en/step_pulse logic.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1):
- Reset held 3 cycles with btn_next low (pressed) → sel=0, cpu_en=0. After release, exactly one next press is accepted and sel=1.
- btn_next pulsed low 3 cycles, then high → sel stays 0 (glitch rejected). Low for 10 cycles → sel=1 exactly at cycle 7 after the press start, no further change.
- Six clean next presses from sel=0 → sel sequence 1,2,3,4,5,0. Then one prev press → sel=5.
- btn_next and btn_prev pressed on the same raw cycle, held 10 cycles → sel unchanged.
- sw_run=0, btn_step held 20 cycles → cpu_en and step_pulse high for exactly 1 cycle. A second press gives a second single pulse.
- sw_run=1 for 10 cycles → run_mode=1 and cpu_en=1 continuously; a step press during it gives step_pulse=0. sw_run back to 0 → cpu_en=0 on the cycle run_mode falls.
